// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program-counter sequencer with call/return stack
module pc_sequencer #(
    parameter int                ADDR_W      = 10,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                imm,
    input  logic [ADDR_W-1:0]                base,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty,
    output logic                             fault
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_REL  = 3'd1;
    localparam logic [2:0] OP_ABS  = 3'd2;
    localparam logic [2:0] OP_IND  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [DW-1:0]     depth_nxt;
    logic [DW-1:0]     depth_m1;
    logic              fault_nxt;
    logic              push;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     top_idx;

    assign pc_inc   = pc + ADDR_W'(1);
    assign depth_m1 = depth - DW'(1);
    assign push_idx = depth[IW-1:0];
    assign top_idx  = depth_m1[IW-1:0];

    // Stack status is a pure function of the registered depth
    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);

    // Next-state selection; stalled or faulting ops leave pc and depth alone
    always_comb begin
        pc_nxt    = pc;
        depth_nxt = depth;
        fault_nxt = fault;
        push      = 1'b0;
        if (en) begin
            case (op)
                OP_INC: pc_nxt = pc_inc;
                OP_REL: pc_nxt = pc + imm;
                OP_ABS: pc_nxt = imm;
                OP_IND: pc_nxt = base + imm;
                OP_CALL: begin
                    if (full) begin
                        fault_nxt = 1'b1;
                    end else begin
                        push      = 1'b1;
                        pc_nxt    = imm;
                        depth_nxt = depth + DW'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        fault_nxt = 1'b1;
                    end else begin
                        pc_nxt    = stack_mem[top_idx];
                        depth_nxt = depth_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC, depth and sticky fault registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_ADDR;
            depth <= '0;
            fault <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            depth <= depth_nxt;
            fault <= fault_nxt;
        end
    end

    // Return-address storage; contents need no reset since depth guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule
